// File: rtl/jtag_tap.sv
// jtag_tap: IEEE 1149.1 TAP controller driving the platform TDR chain.
// Define JTAG_TAP_IDCODE_EN to include the 32-bit IDCODE register.
module jtag_tap #(
    parameter int          IR_WIDTH = 4,
    parameter int          N_TDR    = 4,
    parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
    input  logic                tck,
    input  logic                trstb,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                cti,
    input  logic [N_TDR-1:0]    cto,
    output logic [N_TDR-1:0]    shift,
    output logic [N_TDR-1:0]    capture,
    output logic [N_TDR-1:0]    select,
    output logic [IR_WIDTH-1:0] ir_value
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDDR,
        SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR
    } state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RST = IR_WIDTH'(1);
    localparam logic [31:0]         ID_VAL = {IDCODE[31:1], 1'b1};
`else
    localparam logic [IR_WIDTH-1:0] IR_RST = '1;
`endif

    state_t                state;
    state_t                next_state;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic                  bypass;
    logic                  dr_bit;

    assign cti = tdi;

    // TAP state register
    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) state <= TLR;
        else        state <= next_state;
    end

    // IEEE 1149.1 next-state decode and Moore DR strobes
    always_comb begin
        next_state = state;
        shift      = '0;
        capture    = '0;
        unique case (state)
            TLR:   next_state = tms ? TLR   : RTI;
            RTI:   next_state = tms ? SELDR : RTI;
            SELDR: next_state = tms ? SELIR : CAPDR;
            CAPDR: begin
                next_state = tms ? EX1DR : SHDR;
                shift      = select;
                capture    = select;
            end
            SHDR: begin
                next_state = tms ? EX1DR : SHDR;
                shift      = select;
            end
            EX1DR: next_state = tms ? UPDDR : PAUDR;
            PAUDR: next_state = tms ? EX2DR : PAUDR;
            EX2DR: next_state = tms ? UPDDR : SHDR;
            UPDDR: begin
                next_state = tms ? SELDR : RTI;
                capture    = select;
            end
            SELIR: next_state = tms ? TLR   : CAPIR;
            CAPIR: next_state = tms ? EX1IR : SHIR;
            SHIR:  next_state = tms ? EX1IR : SHIR;
            EX1IR: next_state = tms ? UPDIR : PAUIR;
            PAUIR: next_state = tms ? EX2IR : PAUIR;
            EX2IR: next_state = tms ? UPDIR : SHIR;
            UPDIR: next_state = tms ? SELDR : RTI;
        endcase
    end

    // Instruction shift register and the committed instruction
    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            ir_shift <= IR_CAP;
            ir_value <= IR_RST;
        end else begin
            if (state == CAPIR)
                ir_shift <= IR_CAP;
            else if (state == SHIR)
                ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            if (next_state == TLR)
                ir_value <= IR_RST;
            else if (state == UPDIR)
                ir_value <= ir_shift;
        end
    end

    // Level selects follow the committed instruction only
    for (genvar k = 0; k < N_TDR; k++) begin : g_sel
        assign select[k] = (ir_value == IR_WIDTH'(k + 2));
    end

    // One-bit bypass register
    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb)              bypass <= 1'b0;
        else if (state == CAPDR) bypass <= 1'b0;
        else if (state == SHDR)  bypass <= tdi;
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0] idcode_sr;

    // IDCODE register, shifted out LSB first
    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb)              idcode_sr <= ID_VAL;
        else if (state == CAPDR) idcode_sr <= ID_VAL;
        else if (state == SHDR)  idcode_sr <= {tdi, idcode_sr[31:1]};
    end

    // DR output source: selected TDR, IDCODE, else bypass
    always_comb begin
        dr_bit = bypass;
        if (ir_value == IR_WIDTH'(1))
            dr_bit = idcode_sr[0];
        for (int k = 0; k < N_TDR; k++)
            if (select[k]) dr_bit = cto[k];
    end
`else
    logic unused_idcode;
    assign unused_idcode = ^IDCODE;

    // DR output source: selected TDR, else bypass
    always_comb begin
        dr_bit = bypass;
        for (int k = 0; k < N_TDR; k++)
            if (select[k]) dr_bit = cto[k];
    end
`endif

    // TDO launched on the falling edge; held outside shift states
    always_ff @(negedge tck or negedge trstb) begin
        if (!trstb) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (state == SHIR) begin
            tdo    <= ir_shift[0];
            tdo_en <= 1'b1;
        end else if (state == SHDR) begin
            tdo    <= dr_bit;
            tdo_en <= 1'b1;
        end else begin
            tdo_en <= 1'b0;
        end
    end

endmodule
